// File: rtl/slice_vector.sv
// Katana trajectory tracker: keeps a per-frame position history and reports a lagged
// rise/run vector, its L1 speed and a swipe pulse, holding the vector during a split.
module slice_vector #(
    parameter int DEPTH        = 10,
    parameter int XW           = 11,
    parameter int YW           = 10,
    parameter int FRAME_H      = 1024,
    parameter int FRAME_V      = 768,
    parameter int SPEED_THRESH = 40,
    parameter int LAG_W        = $clog2(DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [10:0]          hcount_in,
    input  logic [9:0]           vcount_in,
    input  logic [XW-1:0]        katana_x,
    input  logic [YW-1:0]        katana_y,
    input  logic                 katana_valid,
    input  logic                 split_in,
    input  logic [LAG_W-1:0]     lag_in,
    output logic signed [YW:0]   rise,
    output logic signed [XW:0]   run,
    output logic [XW+1:0]        speed,
    output logic                 vec_valid,
    output logic                 swipe_out,
    output logic                 frozen
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_TRACK,
        ST_FROZEN
    } state_t;

    function automatic logic [LAG_W-1:0] clamp_lag(input logic [LAG_W-1:0] lag);
        if (lag == '0) begin
            return LAG_W'(1);
        end
        if (int'(lag) > DEPTH - 1) begin
            return LAG_W'(DEPTH - 1);
        end
        return lag;
    endfunction

    function automatic logic signed [XW:0] diff_x(input logic [XW-1:0] a, input logic [XW-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    function automatic logic signed [YW:0] diff_y(input logic [YW-1:0] a, input logic [YW-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    // Operands span at most 2^W-1 in magnitude, so negation never wraps.
    function automatic logic [XW:0] abs_x(input logic signed [XW:0] v);
        return v[XW] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [YW:0] abs_y(input logic signed [YW:0] v);
        return v[YW] ? $unsigned(-v) : $unsigned(v);
    endfunction

    logic                   w_frame_done;
    logic [LAG_W-1:0]       w_lag_eff;
    logic signed [XW:0]     w_run_p0;
    logic signed [YW:0]     w_rise_p0;
    logic [XW+1:0]          w_speed_p0;
    logic                   w_enough;

    logic [XW-1:0]          r_x_hist [DEPTH];
    logic [YW-1:0]          r_y_hist [DEPTH];
    logic [CNT_W-1:0]       r_fill_cnt;
    logic [LAG_W-1:0]       r_lag_p0;
    logic                   r_vld_p0;

    state_t                 r_state;
    logic signed [YW:0]     r_rise_p1;
    logic signed [XW:0]     r_run_p1;
    logic [XW+1:0]          r_speed_p1;
    logic                   r_vld_p1;
    logic                   r_swipe_p1;
    logic                   r_frozen_p1;

    assign w_frame_done = (hcount_in == 11'(FRAME_H)) && (vcount_in == 10'(FRAME_V));
    assign w_lag_eff    = clamp_lag(lag_in);

    // Stage p0: history shift on the frame_done edge; a dropout restarts the fill count.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_x_hist[i] <= '0;
                r_y_hist[i] <= '0;
            end
            r_fill_cnt <= '0;
            r_lag_p0   <= LAG_W'(1);
            r_vld_p0   <= 1'b0;
        end else begin
            r_vld_p0 <= w_frame_done && !split_in;
            if (w_frame_done) begin
                r_lag_p0 <= w_lag_eff;
                if (katana_valid) begin
                    r_x_hist[0] <= katana_x;
                    r_y_hist[0] <= katana_y;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_x_hist[i] <= r_x_hist[i-1];
                        r_y_hist[i] <= r_y_hist[i-1];
                    end
                    if (r_fill_cnt != CNT_W'(DEPTH)) begin
                        r_fill_cnt <= r_fill_cnt + CNT_W'(1);
                    end
                end else begin
                    r_fill_cnt <= '0;
                end
            end
        end
    end

    assign w_run_p0   = diff_x(r_x_hist[0], r_x_hist[r_lag_p0]);
    assign w_rise_p0  = diff_y(r_y_hist[0], r_y_hist[r_lag_p0]);
    assign w_speed_p0 = {1'b0, abs_x(w_run_p0)} + (XW+2)'(abs_y(w_rise_p0));
    assign w_enough   = int'(r_fill_cnt) > int'(r_lag_p0);

    // Stage p1: FSM and registered outputs; split_in has priority over any pending update.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= ST_FILL;
            r_rise_p1   <= '0;
            r_run_p1    <= '0;
            r_speed_p1  <= '0;
            r_vld_p1    <= 1'b0;
            r_swipe_p1  <= 1'b0;
            r_frozen_p1 <= 1'b0;
        end else begin
            r_swipe_p1 <= 1'b0;
            if (split_in) begin
                r_state     <= ST_FROZEN;
                r_frozen_p1 <= 1'b1;
            end else begin
                r_frozen_p1 <= 1'b0;
                if (r_vld_p0) begin
                    if (w_enough) begin
                        r_state    <= ST_TRACK;
                        r_rise_p1  <= w_rise_p0;
                        r_run_p1   <= w_run_p0;
                        r_speed_p1 <= w_speed_p0;
                        r_vld_p1   <= 1'b1;
                        r_swipe_p1 <= (w_speed_p0 >= (XW+2)'(SPEED_THRESH));
                    end else begin
                        r_state  <= ST_FILL;
                        r_vld_p1 <= 1'b0;
                    end
                end else if (r_state == ST_FROZEN) begin
                    r_state  <= w_enough ? ST_TRACK : ST_FILL;
                    r_vld_p1 <= w_enough;
                end
            end
        end
    end

    assign rise      = r_rise_p1;
    assign run       = r_run_p1;
    assign speed     = r_speed_p1;
    assign vec_valid = r_vld_p1;
    assign swipe_out = r_swipe_p1;
    assign frozen    = r_frozen_p1;

endmodule

// File: tb/tb_slice_vector.sv
// Bench for slice_vector: table of per-frame stimulus with expected outputs fed through
// a cycle-stamped scoreboard, plus reset-state and mid-pipeline async reset sequences.
`timescale 1ns/1ps
module tb_slice_vector;

    localparam int DEPTH = 10;
    localparam int XW    = 11;
    localparam int YW    = 10;
    localparam int LAG_W = 4;

    logic              clk_in       = 1'b0;
    logic              rst_in       = 1'b1;
    logic [10:0]       hcount_in    = '0;
    logic [9:0]        vcount_in    = '0;
    logic [XW-1:0]     katana_x     = '0;
    logic [YW-1:0]     katana_y     = '0;
    logic              katana_valid = 1'b0;
    logic              split_in     = 1'b0;
    logic [LAG_W-1:0]  lag_in       = '0;
    logic signed [YW:0] rise;
    logic signed [XW:0] run;
    logic [XW+1:0]     speed;
    logic              vec_valid;
    logic              swipe_out;
    logic              frozen;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int x; int y; bit valid; int lag; bit split;
        bit chk; bit vv; int rise; int run; int speed; bit sw;
    } row_t;

    typedef struct {
        int cyc; int row; int ph;
        bit chk; bit vv; int rise; int run; int speed; bit sw; bit fr;
    } exp_t;

    row_t tbl[$];
    exp_t sb[$];

    bit p_chk = 1'b1;
    bit p_vv  = 1'b0;
    int p_rise = 0, p_run = 0, p_speed = 0;

    slice_vector #(
        .DEPTH(DEPTH), .XW(XW), .YW(YW),
        .FRAME_H(1024), .FRAME_V(768), .SPEED_THRESH(40), .LAG_W(LAG_W)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .katana_x(katana_x), .katana_y(katana_y), .katana_valid(katana_valid),
        .split_in(split_in), .lag_in(lag_in),
        .rise(rise), .run(run), .speed(speed),
        .vec_valid(vec_valid), .swipe_out(swipe_out), .frozen(frozen)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input int row, input int ph, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s row=%0d ph=%0d got=%0d want=%0d", name, row, ph, act, exp);
        end
    endtask

    function automatic void add(input int x, input int y, input bit valid, input int lag,
                                input bit split, input bit chk, input bit vv, input int rs,
                                input int rn, input int sp, input bit sw);
        row_t r;
        r.x = x; r.y = y; r.valid = valid; r.lag = lag; r.split = split;
        r.chk = chk; r.vv = vv; r.rise = rs; r.run = rn; r.speed = sp; r.sw = sw;
        tbl.push_back(r);
    endfunction

    function automatic void push_exp(input int c, input int row, input int ph, input bit chk,
                                     input bit vv, input int rs, input int rn, input int sp,
                                     input bit sw, input bit fr);
        exp_t e;
        e.cyc = c; e.row = row; e.ph = ph; e.chk = chk; e.vv = vv;
        e.rise = rs; e.run = rn; e.speed = sp; e.sw = sw; e.fr = fr;
        sb.push_back(e);
    endfunction

    // One frame: frame_done for one cycle, then idle; outputs expected two edges later.
    task automatic run_row(input int idx);
        row_t r;
        r = tbl[idx];
        @(posedge clk_in); #1;
        hcount_in    = 11'd1024;
        vcount_in    = 10'd768;
        katana_x     = XW'(r.x);
        katana_y     = YW'(r.y);
        katana_valid = r.valid;
        lag_in       = LAG_W'(r.lag);
        split_in     = r.split;
        push_exp(cyc + 1, idx, 1, p_chk, p_vv, p_rise, p_run, p_speed, 1'b0, r.split);
        push_exp(cyc + 2, idx, 2, r.chk, r.vv, r.rise, r.run, r.speed, r.sw, r.split);
        push_exp(cyc + 3, idx, 3, r.chk, r.vv, r.rise, r.run, r.speed, 1'b0, r.split);
        p_chk = r.chk; p_vv = r.vv; p_rise = r.rise; p_run = r.run; p_speed = r.speed;
        @(posedge clk_in); #1;
        hcount_in = '0;
        vcount_in = '0;
        repeat (3) @(posedge clk_in);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            @(posedge clk_in);
            guard++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0 pending", sb.size());
            sb.delete();
        end
    endtask

    always @(negedge clk_in) begin : mon
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL sb_missed row=%0d ph=%0d got=%0d want=%0d", e.row, e.ph, cyc, e.cyc);
            end else begin
                check("vec_valid", e.row, e.ph, int'(vec_valid), int'(e.vv));
                check("swipe_out", e.row, e.ph, int'(swipe_out), int'(e.sw));
                check("frozen", e.row, e.ph, int'(frozen), int'(e.fr));
                if (e.chk) begin
                    check("rise", e.row, e.ph, int'(rise), e.rise);
                    check("run", e.row, e.ph, int'(run), e.run);
                    check("speed", e.row, e.ph, int'(speed), e.speed);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_extra;
        // ramp x=100+10k, y=200+5k at lag 9: valid on the 10th frame
        for (int k = 0; k < 9; k++) add(100 + 10*k, 200 + 5*k, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        add(190, 245, 1, 9, 0, 1, 1, 45, 90, 135, 1);
        // split held for 5 frames while the cursor jumps; outputs hold
        for (int k = 0; k < 5; k++) add(300 + 20*k, 250 + 5*k, 1, 9, 1, 1, 1, 45, 90, 135, 0);
        add(400, 275, 1, 9, 0, 1, 1, 45, 240, 285, 1);
        // dropout then 10 valid frames; slow motion stays below threshold
        add(999, 999, 0, 9, 0, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 9; j++) add(600 + 2*j, 300, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        add(618, 300, 1, 9, 0, 1, 1, 0, 18, 18, 0);
        // lag 0 acts as lag 1
        add(615, 300, 1, 0, 0, 1, 1, 0, -3, 3, 0);
        add(612, 300, 1, 0, 0, 1, 1, 0, -3, 3, 0);
        // extremes at lag 1
        add(0, 1023, 1, 1, 0, 1, 1, 723, -612, 1335, 1);
        add(2047, 0, 1, 1, 0, 1, 1, -1023, 2047, 3070, 1);
        add(0, 1023, 1, 1, 0, 1, 1, 1023, -2047, 3070, 1);
        // speed threshold boundary
        add(40, 1023, 1, 1, 0, 1, 1, 0, 40, 40, 1);
        add(79, 1023, 1, 1, 0, 1, 1, 0, 39, 39, 0);
        // lag 15 clamps to 9
        add(100, 500, 1, 15, 0, 1, 1, 200, -516, 716, 1);
        // dropout, refill at lag 1, then raise lag past the fill count
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(10, 10, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(30, 20, 1, 1, 0, 1, 1, 10, 20, 30, 0);
        add(60, 20, 1, 5, 0, 0, 0, 0, 0, 0, 0);

        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_rise", -1, 0, int'(rise), 0);
        check("rst_run", -1, 0, int'(run), 0);
        check("rst_speed", -1, 0, int'(speed), 0);
        check("rst_vec_valid", -1, 0, int'(vec_valid), 0);
        check("rst_swipe", -1, 0, int'(swipe_out), 0);
        check("rst_frozen", -1, 0, int'(frozen), 0);
        rst_in = 1'b0;

        for (int i = 0; i < tbl.size(); i++) run_row(i);
        drain();

        // async reset at T+1 of a fast update: outputs clear at once, no late swipe
        @(posedge clk_in); #1;
        hcount_in = 11'd1024; vcount_in = 10'd768;
        katana_x = 11'd2000; katana_y = '0; katana_valid = 1'b1; lag_in = 4'd1; split_in = 1'b0;
        @(posedge clk_in); #1;
        hcount_in = '0; vcount_in = '0;
        #2 rst_in = 1'b1;
        #1;
        check("arst_rise", -2, 0, int'(rise), 0);
        check("arst_run", -2, 0, int'(run), 0);
        check("arst_speed", -2, 0, int'(speed), 0);
        check("arst_vec_valid", -2, 0, int'(vec_valid), 0);
        check("arst_swipe", -2, 0, int'(swipe_out), 0);
        check("arst_frozen", -2, 0, int'(frozen), 0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            check("post_rst_swipe", -2, i, int'(swipe_out), 0);
            check("post_rst_vec_valid", -2, i, int'(vec_valid), 0);
        end

        // recovery after reset: history restarts empty
        p_chk = 1'b1; p_vv = 1'b0; p_rise = 0; p_run = 0; p_speed = 0;
        first_extra = tbl.size();
        add(5, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(50, 5, 1, 1, 0, 1, 1, 0, 45, 45, 1);
        for (int i = first_extra; i < tbl.size(); i++) run_row(i);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
